// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: eight-digit multiplexed seven-segment scanner.
//
// Each digit slot is a BLANK phase (anodes dark, BLANK_CYCLES long) followed by a
// DRIVE phase (REFRESH_DIV long). The digits/digit_en inputs are captured once per
// frame, on the edge that starts the BLANK phase of digit 0. Every output is a flop.
//
// Ports:
//   clk        - single clock, rising edge
//   reset_n    - asynchronous reset, active low
//   digits     - eight hex nibbles, nibble k shown on digit k
//   digit_en   - bit k permits digit k to be lit
//   anode      - active-low digit enables, bit k drives digit k
//   seg        - active-low segments {a,b,c,d,e,f,g}, bit 6 = a
//   digit_sel  - index of the digit currently scheduled
//   frame_done - one-cycle pulse when digit_sel wraps 7 -> 0
//
// Optional feature: define LEADING_ZERO_BLANK_EN to darken leading zero digits
// (digit 0 is never blanked by this rule).
module display_scan_ctrl #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] digits,
    input  logic [7:0]  digit_en,
    output logic [7:0]  anode,
    output logic [6:0]  seg,
    output logic [2:0]  digit_sel,
    output logic        frame_done
);

    localparam int unsigned CntMax = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
    localparam logic [CntW-1:0] DriveLast = CntW'(REFRESH_DIV - 1);

    typedef enum logic {StBlank = 1'b0, StDrive = 1'b1} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      sel_q, sel_d;
    logic            started_q;
    logic [31:0]     snap_digits_q, snap_digits_d;
    logic [7:0]      snap_en_q, snap_en_d;
    logic [7:0]      anode_q, anode_d;
    logic [6:0]      seg_q, seg_d;
    logic            frame_done_q, frame_done_d;
    logic [3:0]      nibble;
    logic [7:0]      lz_dark;
`ifdef LEADING_ZERO_BLANK_EN
    logic            zero_run;
`endif

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h01;
            4'h1: s = 7'h4F;
            4'h2: s = 7'h12;
            4'h3: s = 7'h06;
            4'h4: s = 7'h4C;
            4'h5: s = 7'h24;
            4'h6: s = 7'h20;
            4'h7: s = 7'h0F;
            4'h8: s = 7'h00;
            4'h9: s = 7'h04;
            4'hA: s = 7'h08;
            4'hB: s = 7'h60;
            4'hC: s = 7'h31;
            4'hD: s = 7'h42;
            4'hE: s = 7'h30;
            default: s = 7'h38;
        endcase
        return s;
    endfunction

    // Scan sequencing and snapshot capture.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + 1'b1;
        sel_d         = sel_q;
        frame_done_d  = 1'b0;
        snap_digits_d = snap_digits_q;
        snap_en_d     = snap_en_q;
        if (!started_q) begin
            // First edge after reset: this edge begins the BLANK of digit 0.
            state_d       = StBlank;
            cnt_d         = '0;
            sel_d         = 3'd0;
            snap_digits_d = digits;
            snap_en_d     = digit_en;
        end else begin
            case (state_q)
                StBlank: begin
                    if (cnt_q == BlankLast) begin
                        state_d = StDrive;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    if (cnt_q == DriveLast) begin
                        state_d = StBlank;
                        cnt_d   = '0;
                        sel_d   = sel_q + 3'd1;
                        if (sel_q == 3'd7) begin
                            frame_done_d  = 1'b1;
                            snap_digits_d = digits;
                            snap_en_d     = digit_en;
                        end
                    end
                end
            endcase
        end
    end

    // Outputs are decoded from next-state values so the output flops line up with
    // the state register rather than lagging it by a cycle.
    always_comb begin
        nibble  = snap_digits_d[{sel_d, 2'b00} +: 4];
        lz_dark = '0;
`ifdef LEADING_ZERO_BLANK_EN
        zero_run = 1'b1;
        for (int k = 7; k >= 1; k--) begin
            zero_run   = zero_run && (snap_digits_d[4*k +: 4] == 4'h0);
            lz_dark[k] = zero_run;
        end
`endif
        anode_d = 8'hFF;
        seg_d   = 7'h7F;
        if (state_d == StDrive) begin
            seg_d = hex_to_seg(nibble);
            if (snap_en_d[sel_d] && !lz_dark[sel_d]) begin
                anode_d = ~(8'd1 << sel_d);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StBlank;
            cnt_q         <= '0;
            sel_q         <= 3'd0;
            started_q     <= 1'b0;
            snap_digits_q <= '0;
            snap_en_q     <= '0;
            anode_q       <= 8'hFF;
            seg_q         <= 7'h7F;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sel_q         <= sel_d;
            started_q     <= 1'b1;
            snap_digits_q <= snap_digits_d;
            snap_en_q     <= snap_en_d;
            anode_q       <= anode_d;
            seg_q         <= seg_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign anode      = anode_q;
    assign seg        = seg_q;
    assign digit_sel  = sel_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl with REFRESH_DIV=4, BLANK_CYCLES=2.
// A timeline model pushes one expected observation per cycle into a scoreboard
// queue; test tasks pop and compare against the DUT outputs at each falling edge.
module tb_display_scan_ctrl;

    localparam int unsigned RefreshDiv  = 4;
    localparam int unsigned BlankCycles = 2;
    localparam int          SlotLen     = 6;
    localparam int          FrameLen    = 48;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] digits;
    logic [7:0]  digit_en;
    logic [7:0]  anode;
    logic [6:0]  seg;
    logic [2:0]  digit_sel;
    logic        frame_done;

    int tests_run    = 0;
    int tests_failed = 0;
    bit mon_en       = 1'b0;

    typedef struct packed {
        logic [7:0] anode;
        logic [6:0] seg;
        logic [2:0] sel;
        logic       fd;
    } obs_t;

    obs_t sb_q[$];

    display_scan_ctrl #(
        .REFRESH_DIV  (RefreshDiv),
        .BLANK_CYCLES (BlankCycles)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .digits     (digits),
        .digit_en   (digit_en),
        .anode      (anode),
        .seg        (seg),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

    // At most one anode low, and none while the scanner is in BLANK.
    always @(negedge clk) begin
        if (mon_en) begin
            tests_run++;
            if ($countones(~anode) > 1 || (dut.state_q == 1'b0 && anode !== 8'hFF)) begin
                tests_failed++;
                $display("FAIL anode_onehot: anode=%h state=%b, want <=1 low and none in BLANK",
                         anode, dut.state_q);
            end
        end
    end

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h01;  4'h1: s = 7'h4F;  4'h2: s = 7'h12;  4'h3: s = 7'h06;
            4'h4: s = 7'h4C;  4'h5: s = 7'h24;  4'h6: s = 7'h20;  4'h7: s = 7'h0F;
            4'h8: s = 7'h00;  4'h9: s = 7'h04;  4'hA: s = 7'h08;  4'hB: s = 7'h60;
            4'hC: s = 7'h31;  4'hD: s = 7'h42;  4'hE: s = 7'h30;  default: s = 7'h38;
        endcase
        return s;
    endfunction

    function automatic bit lz_dark(input logic [31:0] d, input int k);
`ifdef LEADING_ZERO_BLANK_EN
        if (k == 0) return 1'b0;
        return ((d >> (4 * k)) == 32'h0);
`else
        return 1'b0;
`endif
    endfunction

    // Expected outputs for cycle c, where cycle 0 follows the first edge after reset.
    function automatic obs_t model(input logic [31:0] d, input logic [7:0] en, input int c);
        obs_t m;
        int slot = c / SlotLen;
        int ph   = c % SlotLen;
        int dg   = slot % 8;
        m.sel   = 3'(dg);
        m.fd    = (c > 0) && (c % FrameLen == 0);
        m.anode = 8'hFF;
        m.seg   = 7'h7F;
        if (ph >= int'(BlankCycles)) begin
            m.seg = hex_seg(d[4*dg +: 4]);
            if (en[dg] && !lz_dark(d, dg)) m.anode = ~(8'd1 << dg);
        end
        return m;
    endfunction

    task automatic push_frame(input logic [31:0] d, input logic [7:0] en, input int frame);
        for (int c = frame * FrameLen; c < (frame + 1) * FrameLen; c++) begin
            sb_q.push_back(model(d, en, c));
        end
    endtask

    task automatic sample(output obs_t got, output obs_t want, output bit have);
        @(negedge clk);
        got  = {anode, seg, digit_sel, frame_done};
        have = (sb_q.size() > 0);
        want = have ? sb_q.pop_front() : '0;
    endtask

    // Reset, then release just after a rising edge; returns right after the first
    // edge with reset_n high, so the next falling edge samples cycle 0.
    task automatic apply_reset(input logic [31:0] d, input logic [7:0] en);
        reset_n  = 1'b0;
        digits   = d;
        digit_en = en;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        digits   = 32'h76543210;
        digit_en = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        tests_run++;
        if (anode !== 8'hFF) begin
            tests_failed++;
            $display("FAIL reset_anode: got %h want ff", anode);
        end
        tests_run++;
        if (seg !== 7'h7F) begin
            tests_failed++;
            $display("FAIL reset_seg: got %h want 7f", seg);
        end
        tests_run++;
        if (digit_sel !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_digit_sel: got %0d want 0", digit_sel);
        end
        tests_run++;
        if (frame_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_frame_done: got %b want 0", frame_done);
        end
    endtask

    task automatic test_basic_scan();
        obs_t got, want;
        bit   have;
        apply_reset(32'h76543210, 8'hFF);
        for (int f = 0; f < 3; f++) push_frame(32'h76543210, 8'hFF, f);
        for (int c = 0; c < 2 * FrameLen + 4; c++) begin
            sample(got, want, have);
            tests_run++;
            if (!have) begin
                tests_failed++;
                $display("FAIL basic_scan cyc %0d: scoreboard empty", c);
            end else if (got !== want) begin
                tests_failed++;
                $display("FAIL basic_scan cyc %0d: got a=%h s=%h sel=%0d fd=%b want a=%h s=%h sel=%0d fd=%b",
                         c, got.anode, got.seg, got.sel, got.fd,
                         want.anode, want.seg, want.sel, want.fd);
            end
        end
    endtask

    task automatic test_digit_en();
        obs_t got, want;
        bit   have;
        apply_reset(32'h76543210, 8'h0F);
        push_frame(32'h76543210, 8'h0F, 0);
        for (int c = 0; c < FrameLen; c++) begin
            sample(got, want, have);
            tests_run++;
            if (!have) begin
                tests_failed++;
                $display("FAIL digit_en cyc %0d: scoreboard empty", c);
            end else if (got !== want) begin
                tests_failed++;
                $display("FAIL digit_en cyc %0d: got a=%h s=%h sel=%0d fd=%b want a=%h s=%h sel=%0d fd=%b",
                         c, got.anode, got.seg, got.sel, got.fd,
                         want.anode, want.seg, want.sel, want.fd);
            end
        end
    endtask

    task automatic test_snapshot();
        obs_t got, want;
        bit   have;
        apply_reset(32'h0, 8'hFF);
        push_frame(32'h0, 8'hFF, 0);
        for (int c = 0; c < 2 * FrameLen; c++) begin
            sample(got, want, have);
            tests_run++;
            if (!have) begin
                tests_failed++;
                $display("FAIL snapshot cyc %0d: scoreboard empty", c);
            end else if (got !== want) begin
                tests_failed++;
                $display("FAIL snapshot cyc %0d: got a=%h s=%h sel=%0d fd=%b want a=%h s=%h sel=%0d fd=%b",
                         c, got.anode, got.seg, got.sel, got.fd,
                         want.anode, want.seg, want.sel, want.fd);
            end
            // First DRIVE cycle of digit 3: change inputs; only the next frame sees them.
            if (c == 3 * SlotLen + 2) begin
                digits = 32'hFFFFFFFF;
                push_frame(32'hFFFFFFFF, 8'hFF, 1);
            end
        end
    endtask

    task automatic test_reset_mid_drive();
        obs_t got, want;
        bit   have;
        apply_reset(32'h76543210, 8'hFF);
        push_frame(32'h76543210, 8'hFF, 0);
        for (int c = 0; c <= 5 * SlotLen + 3; c++) begin
            sample(got, want, have);
            tests_run++;
            if (!have || got !== want) begin
                tests_failed++;
                $display("FAIL mid_reset_pre cyc %0d: got a=%h s=%h sel=%0d want a=%h s=%h sel=%0d",
                         c, got.anode, got.seg, got.sel, want.anode, want.seg, want.sel);
            end
        end
        // Falling edge of a digit-5 DRIVE cycle; next rising edge is 5 ns away.
        #1 reset_n = 1'b0;
        #1;
        tests_run++;
        if (anode !== 8'hFF || seg !== 7'h7F || digit_sel !== 3'd0) begin
            tests_failed++;
            $display("FAIL mid_reset_async: got a=%h s=%h sel=%0d want a=ff s=7f sel=0",
                     anode, seg, digit_sel);
        end
        #2 reset_n = 1'b1;
        sb_q.delete();
        push_frame(32'h76543210, 8'hFF, 0);
        for (int c = 0; c < 2 * SlotLen + 2; c++) begin
            sample(got, want, have);
            tests_run++;
            if (!have) begin
                tests_failed++;
                $display("FAIL mid_reset_post cyc %0d: scoreboard empty", c);
            end else if (got !== want) begin
                tests_failed++;
                $display("FAIL mid_reset_post cyc %0d: got a=%h s=%h sel=%0d fd=%b want a=%h s=%h sel=%0d fd=%b",
                         c, got.anode, got.seg, got.sel, got.fd,
                         want.anode, want.seg, want.sel, want.fd);
            end
        end
    endtask

    task automatic test_leading_zero();
        obs_t        got, want;
        bit          have;
        logic [31:0] pats [2];
        pats[0] = 32'h00000A05;
        pats[1] = 32'h0;
        for (int p = 0; p < 2; p++) begin
            apply_reset(pats[p], 8'hFF);
            push_frame(pats[p], 8'hFF, 0);
            for (int c = 0; c < FrameLen; c++) begin
                sample(got, want, have);
                tests_run++;
                if (!have) begin
                    tests_failed++;
                    $display("FAIL leading_zero p%0d cyc %0d: scoreboard empty", p, c);
                end else if (got !== want) begin
                    tests_failed++;
                    $display("FAIL leading_zero p%0d cyc %0d: got a=%h s=%h sel=%0d want a=%h s=%h sel=%0d",
                             p, c, got.anode, got.seg, got.sel,
                             want.anode, want.seg, want.sel);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_digit_en();
        test_snapshot();
        test_reset_mid_drive();
        test_leading_zero();
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
